// File: rtl/ddr_arb_pkg.sv
// Shared types and default widths for the DDR3 port arbiter.
package ddr_arb_pkg;

  localparam int unsigned DefAddrW  = 32;
  localparam int unsigned DefDataW  = 64;
  localparam int unsigned DefBurstW = 8;

  typedef enum logic [1:0] {
    IDLE,
    WR_CMD,
    RD_CMD,
    RD_DATA
  } state_e;

  typedef enum logic [1:0] {
    REQ_DL,
    REQ_VID,
    REQ_ROM
  } req_e;

endpackage

// File: rtl/ddr_arb_priority.sv
// Combinational grant logic: download write first, then round-robin between the two readers.
module ddr_arb_priority
  import ddr_arb_pkg::*;
(
  input  logic       dl_req,
  input  logic       vid_req,
  input  logic       rom_req,
  input  req_e       rr_last,
  output logic [2:0] grant,    // {rom, vid, dl}
  output req_e       rr_next
);

  always_comb begin
    grant   = 3'b000;
    rr_next = rr_last;
    if (dl_req) begin
      grant = 3'b001;
    end else if (vid_req && rom_req) begin
      if (rr_last == REQ_VID) begin
        grant   = 3'b100;
        rr_next = REQ_ROM;
      end else begin
        grant   = 3'b010;
        rr_next = REQ_VID;
      end
    end else if (vid_req) begin
      grant   = 3'b010;
      rr_next = REQ_VID;
    end else if (rom_req) begin
      grant   = 3'b100;
      rr_next = REQ_ROM;
    end
  end

endmodule

// File: rtl/ddr_arbiter.sv
// Shares one DDR3 port between the download writer, video reader and ROM cache reader.
// Optional DDR_ARB_STATS_EN adds saturating command/stall counters.
module ddr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned BURST_W = DefBurstW
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                dl_wr,
  input  logic [ADDR_W-1:0]   dl_addr,
  input  logic [DATA_W-1:0]   dl_din,
  input  logic [DATA_W/8-1:0] dl_mask,
  output logic                dl_wait,
  input  logic                vid_rd,
  input  logic [ADDR_W-1:0]   vid_addr,
  input  logic [BURST_W-1:0]  vid_burst,
  output logic                vid_wait,
  output logic                vid_valid,
  input  logic                rom_rd,
  input  logic [ADDR_W-1:0]   rom_addr,
  input  logic [BURST_W-1:0]  rom_burst,
  output logic                rom_wait,
  output logic                rom_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                ddr_rd,
  output logic                ddr_wr,
  output logic [ADDR_W-1:0]   ddr_addr,
  output logic [BURST_W-1:0]  ddr_burst,
  output logic [DATA_W/8-1:0] ddr_mask,
  output logic [DATA_W-1:0]   ddr_din,
  input  logic [DATA_W-1:0]   ddr_dout,
  input  logic                ddr_wait_req,
  input  logic                ddr_valid
`ifdef DDR_ARB_STATS_EN
  ,
  output logic [31:0]         stat_dl_cnt,
  output logic [31:0]         stat_vid_cnt,
  output logic [31:0]         stat_rom_cnt,
  output logic [31:0]         stat_stall_cnt
`endif
);

  state_e               state_q, state_d;
  req_e                 rr_last_q, rr_last_d, rr_next;
  logic                 owner_rom_q, owner_rom_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    din_q, din_d;
  logic [DATA_W/8-1:0]  mask_q, mask_d;
  logic [BURST_W-1:0]   burst_q, burst_d, rd_burst;
  logic [BURST_W-1:0]   cnt_q, cnt_d;
  logic [2:0]           grant;
  logic                 idle;

  ddr_arb_priority u_priority (
    .dl_req  (dl_wr),
    .vid_req (vid_rd),
    .rom_req (rom_rd),
    .rr_last (rr_last_q),
    .grant   (grant),
    .rr_next (rr_next)
  );

  // Gated with reset_n so the stalls read as 1 while reset is held.
  assign idle     = (state_q == IDLE) && reset_n;
  assign dl_wait  = !(idle && grant[0]);
  assign vid_wait = !(idle && grant[1]);
  assign rom_wait = !(idle && grant[2]);

  assign rd_burst = grant[2] ? rom_burst : vid_burst;

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    owner_rom_d = owner_rom_q;
    addr_d      = addr_q;
    din_d       = din_q;
    mask_d      = mask_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant[0]) begin
          addr_d  = dl_addr;
          din_d   = dl_din;
          mask_d  = dl_mask;
          burst_d = BURST_W'(1);
          state_d = WR_CMD;
        end else if (grant[1] || grant[2]) begin
          addr_d      = grant[2] ? rom_addr : vid_addr;
          mask_d      = '1;
          burst_d     = (rd_burst == '0) ? BURST_W'(1) : rd_burst;
          owner_rom_d = grant[2];
          rr_last_d   = rr_next;
          cnt_d       = '0;
          state_d     = RD_CMD;
        end
      end
      WR_CMD: begin
        if (!ddr_wait_req) state_d = IDLE;
      end
      RD_CMD: begin
        // Early beats are illegal but still counted so the burst cannot overrun.
        if (ddr_valid) cnt_d = cnt_q + BURST_W'(1);
        if (!ddr_wait_req) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (ddr_valid) begin
          if (cnt_q >= burst_q - BURST_W'(1)) state_d = IDLE;
          else cnt_d = cnt_q + BURST_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_last_q   <= REQ_ROM;
      owner_rom_q <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      mask_q      <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      owner_rom_q <= owner_rom_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      mask_q      <= mask_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ddr_wr    = (state_q == WR_CMD);
  assign ddr_rd    = (state_q == RD_CMD);
  assign ddr_addr  = addr_q;
  assign ddr_din   = din_q;
  assign ddr_mask  = mask_q;
  assign ddr_burst = burst_q;
  assign rd_data   = ddr_dout;

  logic rd_phase;
  assign rd_phase  = (state_q == RD_CMD) || (state_q == RD_DATA);
  assign vid_valid = rd_phase && !owner_rom_q && ddr_valid;
  assign rom_valid = rd_phase && owner_rom_q && ddr_valid;

`ifdef DDR_ARB_STATS_EN
  logic stall;
  assign stall = ((state_q == WR_CMD) || (state_q == RD_CMD)) && ddr_wait_req;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      stat_dl_cnt    <= '0;
      stat_vid_cnt   <= '0;
      stat_rom_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (!dl_wait && stat_dl_cnt != '1) stat_dl_cnt <= stat_dl_cnt + 32'd1;
      if (!vid_wait && stat_vid_cnt != '1) stat_vid_cnt <= stat_vid_cnt + 32'd1;
      if (!rom_wait && stat_rom_cnt != '1) stat_rom_cnt <= stat_rom_cnt + 32'd1;
      if (stall && stat_stall_cnt != '1) stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed-vector bench for ddr_arbiter: per-cycle stimulus table plus multi-cycle corner sequences.
module tb_ddr_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic        dl_wr = 1'b0, vid_rd = 1'b0, rom_rd = 1'b0;
  logic [31:0] dl_addr = '0, vid_addr = '0, rom_addr = '0;
  logic [63:0] dl_din = '0, ddr_dout = '0;
  logic [7:0]  dl_mask = '0, vid_burst = '0, rom_burst = '0;
  logic        ddr_wait_req = 1'b0, ddr_valid = 1'b0;
  logic        dl_wait, vid_wait, vid_valid, rom_wait, rom_valid;
  logic [63:0] rd_data, ddr_din;
  logic        ddr_rd, ddr_wr;
  logic [31:0] ddr_addr;
  logic [7:0]  ddr_burst, ddr_mask;
`ifdef DDR_ARB_STATS_EN
  logic [31:0] stat_dl_cnt, stat_vid_cnt, stat_rom_cnt, stat_stall_cnt;
`endif

  ddr_arbiter dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .dl_wr        (dl_wr),
    .dl_addr      (dl_addr),
    .dl_din       (dl_din),
    .dl_mask      (dl_mask),
    .dl_wait      (dl_wait),
    .vid_rd       (vid_rd),
    .vid_addr     (vid_addr),
    .vid_burst    (vid_burst),
    .vid_wait     (vid_wait),
    .vid_valid    (vid_valid),
    .rom_rd       (rom_rd),
    .rom_addr     (rom_addr),
    .rom_burst    (rom_burst),
    .rom_wait     (rom_wait),
    .rom_valid    (rom_valid),
    .rd_data      (rd_data),
    .ddr_rd       (ddr_rd),
    .ddr_wr       (ddr_wr),
    .ddr_addr     (ddr_addr),
    .ddr_burst    (ddr_burst),
    .ddr_mask     (ddr_mask),
    .ddr_din      (ddr_din),
    .ddr_dout     (ddr_dout),
    .ddr_wait_req (ddr_wait_req),
    .ddr_valid    (ddr_valid)
`ifdef DDR_ARB_STATS_EN
    ,
    .stat_dl_cnt    (stat_dl_cnt),
    .stat_vid_cnt   (stat_vid_cnt),
    .stat_rom_cnt   (stat_rom_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  // {dl_wait, vid_wait, rom_wait, ddr_wr, ddr_rd, vid_valid, rom_valid}
  logic [6:0] obs;
  assign obs = {dl_wait, vid_wait, rom_wait, ddr_wr, ddr_rd, vid_valid, rom_valid};
  localparam logic [6:0] ObsIdle = 7'b1110000;

  typedef struct packed {
    logic [4:0] stim;  // {dl_wr, vid_rd, rom_rd, ddr_wait_req, ddr_valid}
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[31];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [4:0] s);
    {dl_wr, vid_rd, rom_rd, ddr_wait_req, ddr_valid} = s;
  endtask

  task automatic step;
    @(negedge clk_sys);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit last_rom;
    bit exp_rom;

    vecs[0]  = '{5'b10000, 7'b0110000};  // write accepted
    vecs[1]  = '{5'b00000, 7'b1111000};  // ddr_wr one cycle later
    vecs[2]  = '{5'b00000, 7'b1110000};
    vecs[3]  = '{5'b10010, 7'b0110000};  // accept regardless of ddr busy
    vecs[4]  = '{5'b00010, 7'b1111000};  // write held while busy
    vecs[5]  = '{5'b00000, 7'b1111000};
    vecs[6]  = '{5'b00000, 7'b1110000};
    vecs[7]  = '{5'b01000, 7'b1010000};  // vid burst 4 accepted
    vecs[8]  = '{5'b00010, 7'b1110100};
    vecs[9]  = '{5'b00010, 7'b1110100};
    vecs[10] = '{5'b00010, 7'b1110100};
    vecs[11] = '{5'b00000, 7'b1110100};  // 4th ddr_rd cycle, taken
    vecs[12] = '{5'b00001, 7'b1110010};
    vecs[13] = '{5'b00000, 7'b1110000};
    vecs[14] = '{5'b00001, 7'b1110010};
    vecs[15] = '{5'b00001, 7'b1110010};
    vecs[16] = '{5'b00001, 7'b1110010};  // last beat
    vecs[17] = '{5'b00001, 7'b1110000};  // stray beat in IDLE is not routed
    vecs[18] = '{5'b11100, 7'b0110000};  // dl beats both readers
    vecs[19] = '{5'b01100, 7'b1111000};
    vecs[20] = '{5'b01100, 7'b1100000};  // rr_last=VID so ROM wins
    vecs[21] = '{5'b01000, 7'b1110100};
    vecs[22] = '{5'b01001, 7'b1110001};
    vecs[23] = '{5'b01001, 7'b1110001};  // rom burst 2 done
    vecs[24] = '{5'b01000, 7'b1010000};  // waiting vid now granted
    vecs[25] = '{5'b00000, 7'b1110100};
    vecs[26] = '{5'b00001, 7'b1110010};
    vecs[27] = '{5'b00001, 7'b1110010};
    vecs[28] = '{5'b00001, 7'b1110010};
    vecs[29] = '{5'b00001, 7'b1110010};
    vecs[30] = '{5'b00000, 7'b1110000};

    dl_addr   = 32'h100;
    dl_din    = 64'hA5A5;
    dl_mask   = 8'hFF;
    vid_addr  = 32'h2000;
    vid_burst = 8'd4;
    rom_addr  = 32'h3000;
    rom_burst = 8'd2;

    #3 reset_n = 1'b0;
    step();
    #1;
    chk("reset_obs", 64'(obs), 64'(ObsIdle));
    chk("reset_ddr_addr", 64'(ddr_addr), 64'h0);
    chk("reset_ddr_din", ddr_din, 64'h0);
    chk("reset_ddr_mask", 64'(ddr_mask), 64'h0);
    chk("reset_ddr_burst", 64'(ddr_burst), 64'h0);
    step();
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 31; i++) begin
      drive(vecs[i].stim);
      ddr_dout = 64'(i);
      #1;
      chk($sformatf("vec%0d", i), 64'(obs), 64'(vecs[i].exp));
      step();
    end

    // Write fields latched at accept and held while busy.
    drive(5'b10000);
    #1 chk("wr_accept", 64'(dl_wait), 64'h0);
    step();
    drive(5'b00010);
    dl_addr = 32'hDEAD;
    dl_din  = 64'h1234;
    dl_mask = 8'h0F;
    #1;
    chk("wr_addr", 64'(ddr_addr), 64'h100);
    chk("wr_din", ddr_din, 64'hA5A5);
    chk("wr_mask", 64'(ddr_mask), 64'hFF);
    chk("wr_burst", 64'(ddr_burst), 64'h1);
    step();
    drive(5'b00000);
    #1 chk("wr_hold", 64'({ddr_wr, ddr_addr}), {31'h0, 1'b1, 32'h100});
    step();
    #1 chk("wr_done", 64'(obs), 64'(ObsIdle));

    // Both readers held continuously: grants must alternate.
    vid_burst = 8'd2;
    rom_burst = 8'd2;
    last_rom  = 1'b0;
    for (int g = 0; g < 4; g++) begin
      drive(5'b01100);
      #1;
      exp_rom = !last_rom;
      last_rom = exp_rom;
      chk($sformatf("rr_grant%0d", g), 64'({vid_wait, rom_wait}), exp_rom ? 64'h2 : 64'h1);
      step();
      #1 chk($sformatf("rr_addr%0d", g), 64'({ddr_rd, ddr_addr}),
             {31'h0, 1'b1, exp_rom ? 32'h3000 : 32'h2000});
      step();
      for (int b = 0; b < 2; b++) begin
        drive(5'b01101);
        #1 chk($sformatf("rr_beat%0d_%0d", g, b), 64'({vid_valid, rom_valid}),
               exp_rom ? 64'h1 : 64'h2);
        step();
      end
    end
    drive(5'b00000);
    step();

    // dl_wr during an 8-beat rom burst: reads finish, then dl beats pending vid.
    dl_addr   = 32'h100;
    dl_din    = 64'hA5A5;
    dl_mask   = 8'hFF;
    rom_burst = 8'd8;
    vid_burst = 8'd4;
    drive(5'b00100);
    #1 chk("rom8_accept", 64'(rom_wait), 64'h0);
    step();
    drive(5'b00000);
    #1 chk("rom8_burst", 64'(ddr_burst), 64'h8);
    step();
    for (int b = 1; b <= 8; b++) begin
      drive({(b >= 2), (b >= 2), 3'b001});
      ddr_dout = 64'hBEEF_0000 + 64'(b);
      #1;
      chk($sformatf("rom8_beat%0d", b), 64'({rom_valid, vid_valid, dl_wait, vid_wait}), 64'hB);
      chk($sformatf("rom8_data%0d", b), rd_data, 64'hBEEF_0000 + 64'(b));
      step();
    end
    drive(5'b11000);
    #1 chk("dl_after_burst", 64'({dl_wait, vid_wait}), 64'h1);
    step();
    drive(5'b01000);
    #1 chk("dl_wr_cmd", 64'(ddr_wr), 64'h1);
    step();
    #1 chk("vid_after_dl", 64'(vid_wait), 64'h0);
    step();
    drive(5'b00000);
    step();
    for (int b = 0; b < 4; b++) begin
      drive(5'b00001);
      step();
    end
    drive(5'b00000);
    #1 chk("flush_idle", 64'(obs), 64'(ObsIdle));
    step();

    // Burst 0 clamps to 1.
    rom_burst = 8'd0;
    drive(5'b00100);
    #1 chk("b0_accept", 64'(rom_wait), 64'h0);
    step();
    drive(5'b00000);
    #1 chk("b0_burst", 64'(ddr_burst), 64'h1);
    step();
    drive(5'b00001);
    #1 chk("b0_beat", 64'(rom_valid), 64'h1);
    step();
    drive(5'b10000);
    #1 chk("b0_idle", 64'(dl_wait), 64'h0);
    step();
    drive(5'b00000);
    step();
    step();

    // Async reset mid-burst after 3 of 8 beats.
    vid_burst = 8'd8;
    drive(5'b01000);
    step();
    drive(5'b00000);
    step();
    for (int b = 0; b < 3; b++) begin
      drive(5'b00001);
      step();
    end
    drive(5'b00001);
    #1 chk("pre_reset_beat", 64'(vid_valid), 64'h1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_reset_obs", 64'(obs), 64'(ObsIdle));
    chk("async_reset_addr", 64'({ddr_burst, ddr_addr}), 64'h0);
    step();
    drive(5'b00000);
    reset_n = 1'b1;
    step();
    vid_burst = 8'd1;
    rom_burst = 8'd2;
    drive(5'b01100);
    #1 chk("post_reset_grant", 64'({vid_wait, rom_wait}), 64'h1);
    step();
    drive(5'b00000);
    #1 chk("post_reset_cmd", 64'({ddr_rd, ddr_burst, ddr_addr}), {23'h0, 1'b1, 8'h1, 32'h2000});
    step();
    drive(5'b00001);
    #1 chk("post_reset_beat", 64'({vid_valid, rom_valid}), 64'h2);
    step();
    drive(5'b00000);
    #1 chk("post_reset_idle", 64'(obs), 64'(ObsIdle));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
